bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter_if.sv | 38 +++
 rtl/bram_arbiter.sv | 109 ++++++++++
 tb/tb_bram_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_if.sv
// Request/response bundle between the instruction/data requesters and the
// BRAM arbiter. The master side is the requester; the slave side is the arbiter.
interface bram_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8
);
  localparam int DW = NB_COL * COL_WIDTH;

  logic                  i_req_valid;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  i_req_ready;
  logic                  i_rsp_valid;
  logic [DW-1:0]         i_rsp_data;

  logic                  d_req_valid;
  logic                  d_req_we;
  logic [NB_COL-1:0]     d_req_be;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic [DW-1:0]         d_req_wdata;
  logic                  d_req_ready;
  logic                  d_rsp_valid;
  logic [DW-1:0]         d_rsp_data;

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data
  );
endinterface

// File: rtl/bram_arbiter.sv
// Shares one BRAM (one write port, one read port) between an instruction
// port (read-only) and a data port (reads and writes). Writes always pass
// straight through; reads are arbitrated round-robin and their responses are
// tagged through a fixed-latency pipeline.
// Define BRAM_ARBITER_HIPERF_EN when the BRAM is built with its output
// register: read latency becomes 2 and mem_out_r_en is held high.
//
// state | meaning
// RR_D  | data port wins the next contested read
// RR_I  | instruction port wins the next contested read
module bram_arbiter #(
  parameter int  ADDR_WIDTH = 12,
  parameter int  NB_COL     = 4,
  parameter int  COL_WIDTH  = 8,
  localparam int DW         = NB_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_arbiter_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DW-1:0]         mem_ram_in,
  output logic [NB_COL-1:0]     mem_byte_w_en,
  output logic                  mem_r_en,
  output logic                  mem_out_res,
  output logic                  mem_out_r_en,
  input  logic [DW-1:0]         mem_r_out
);

`ifdef BRAM_ARBITER_HIPERF_EN
  localparam int L = 2;
  localparam logic OUT_REG_EN = 1'b1;
`else
  localparam int L = 1;
  localparam logic OUT_REG_EN = 1'b0;
`endif

  typedef enum logic {RR_D = 1'b0, RR_I = 1'b1} rr_t;

  rr_t          rr_q, rr_d;
  logic         d_wr, d_rd, hazard, i_cand;
  logic         grant_i, grant_d;
  logic [L-1:0] i_tag, d_tag;

  // A write and an instruction read of the same word in one cycle would read
  // stale data, so the read is held off one cycle until the write lands.
  assign d_wr   = !rst && bus.d_req_valid && bus.d_req_we;
  assign d_rd   = !rst && bus.d_req_valid && !bus.d_req_we;
  assign hazard = bus.i_req_valid && d_wr && (bus.d_req_addr == bus.i_req_addr)
                  && (|bus.d_req_be);
  assign i_cand = !rst && bus.i_req_valid && !hazard;

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= RR_D;
    else     rr_q <= rr_d;
  end

  // Grant selection; the pointer only moves when both ports want the read port.
  always_comb begin
    rr_d    = rr_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_cand && d_rd) begin
      if (rr_q == RR_I) begin
        grant_i = 1'b1;
        rr_d    = RR_D;
      end else begin
        grant_d = 1'b1;
        rr_d    = RR_I;
      end
    end else begin
      grant_i = i_cand;
      grant_d = d_rd;
    end
  end

  assign bus.i_req_ready = !rst && !hazard && !(d_rd && rr_q == RR_D);
  assign bus.d_req_ready = !rst && (bus.d_req_we || !(i_cand && rr_q == RR_I));

  assign mem_wr_addr   = bus.d_req_addr;
  assign mem_ram_in    = bus.d_req_wdata;
  assign mem_byte_w_en = d_wr ? bus.d_req_be : '0;
  assign mem_r_en      = grant_i || grant_d;
  assign mem_rd_addr   = grant_i ? bus.i_req_addr : bus.d_req_addr;
  assign mem_out_res   = rst;
  assign mem_out_r_en  = OUT_REG_EN;

  // Response tag pipeline, aligned with the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_tag <= '0;
      d_tag <= '0;
    end else begin
      i_tag[0] <= grant_i;
      d_tag[0] <= grant_d;
      for (int k = 1; k < L; k++) begin
        i_tag[k] <= i_tag[k-1];
        d_tag[k] <= d_tag[k-1];
      end
    end
  end

  assign bus.i_rsp_valid = !rst && i_tag[L-1];
  assign bus.d_rsp_valid = !rst && d_tag[L-1];
  assign bus.i_rsp_data  = mem_r_out;
  assign bus.d_rsp_data  = mem_r_out;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural BRAM and a response
// scoreboard keyed on tag, data and arrival cycle.
module tb_bram_arbiter;
`ifdef BRAM_ARBITER_HIPERF_EN
  localparam int L = 2;
  localparam logic EXP_OUT_R_EN = 1'b1;
`else
  localparam int L = 1;
  localparam logic EXP_OUT_R_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_wr_addr, mem_rd_addr;
  logic [31:0] mem_ram_in, mem_r_out;
  logic [3:0]  mem_byte_w_en;
  logic        mem_r_en, mem_out_res, mem_out_r_en;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bram_arbiter_if bus ();

  bram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .mem_wr_addr   (mem_wr_addr),
    .mem_rd_addr   (mem_rd_addr),
    .mem_ram_in    (mem_ram_in),
    .mem_byte_w_en (mem_byte_w_en),
    .mem_r_en      (mem_r_en),
    .mem_out_res   (mem_out_res),
    .mem_out_r_en  (mem_out_r_en),
    .mem_r_out     (mem_r_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM with optional output register.
  logic [31:0] bram [0:4095];
  logic [31:0] rd_q, out_q;
  always @(posedge clk) begin
    if (mem_r_en) rd_q <= bram[mem_rd_addr];
    for (int b = 0; b < 4; b++)
      if (mem_byte_w_en[b]) bram[mem_wr_addr][8*b +: 8] <= mem_ram_in[8*b +: 8];
    if (mem_out_res)       out_q <= '0;
    else if (mem_out_r_en) out_q <= rd_q;
  end
`ifdef BRAM_ARBITER_HIPERF_EN
  assign mem_r_out = out_q;
`else
  assign mem_r_out = rd_q;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: reference memory plus expected responses.
  typedef struct {
    bit          is_i;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:4095];

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      bit   have;
      exp_t e;
      have = (sb.size() > 0) && (sb[0].due == cyc);
      if (have) e = sb[0];
      check("rsp_i_valid", bus.i_rsp_valid, have && e.is_i);
      check("rsp_d_valid", bus.d_rsp_valid, have && !e.is_i);
      if (have) begin
        void'(sb.pop_front());
        check(e.is_i ? "rsp_i_data" : "rsp_d_data",
              e.is_i ? bus.i_rsp_data : bus.d_rsp_data, e.data);
      end
      if (bus.i_req_valid && bus.i_req_ready)
        sb.push_back('{1'b1, ref_mem[bus.i_req_addr], cyc + L});
      if (bus.d_req_valid && !bus.d_req_we && bus.d_req_ready)
        sb.push_back('{1'b0, ref_mem[bus.d_req_addr], cyc + L});
      if (bus.d_req_valid && bus.d_req_we && bus.d_req_ready)
        for (int b = 0; b < 4; b++)
          if (bus.d_req_be[b]) ref_mem[bus.d_req_addr][8*b +: 8] = bus.d_req_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.d_req_be    = '0;
    bus.d_req_addr  = '0;
    bus.d_req_wdata = '0;
  endtask

  // Waits for a response on the chosen port, bounded; reports latency and data.
  task automatic wait_rsp(input bit is_i, input int g, output int lat, output logic [31:0] data);
    lat  = -1;
    data = 'x;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (is_i ? bus.i_rsp_valid : bus.d_rsp_valid) begin
        lat  = cyc - g;
        data = is_i ? bus.i_rsp_data : bus.d_rsp_data;
        break;
      end
    end
  endtask

  initial begin
    int          g, lat;
    logic [31:0] data;

    for (int a = 0; a < 4096; a++) begin
      bram[a]    <= 32'hA500_0000 | a;
      ref_mem[a]  = 32'hA500_0000 | a;
    end
    bram[12'h010] <= 32'hDEAD_BEEF;  ref_mem[12'h010] = 32'hDEAD_BEEF;
    bram[12'h020] <= 32'hFFFF_FFFF;  ref_mem[12'h020] = 32'hFFFF_FFFF;

    // Reset with requests pending: nothing may be accepted or enabled.
    rst = 1'b1;
    idle_inputs();
    bus.i_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b1;
    bus.d_req_be    = 4'hF;
    step();
    @(negedge clk);
    check("rst_i_ready", bus.i_req_ready, 1'b0);
    check("rst_d_ready", bus.d_req_ready, 1'b0);
    check("rst_r_en", mem_r_en, 1'b0);
    check("rst_bwe", mem_byte_w_en, 4'h0);
    check("rst_out_res", mem_out_res, 1'b1);
    check("rst_rsp_valid", {bus.i_rsp_valid, bus.d_rsp_valid}, 2'b00);
    check("out_r_en", mem_out_r_en, EXP_OUT_R_EN);
    step();
    rst = 1'b0;
    idle_inputs();

    // Single instruction read of preloaded word.
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 12'h010;
    @(negedge clk);
    check("i_rd_ready", bus.i_req_ready, 1'b1);
    check("i_rd_mem_addr", mem_rd_addr, 12'h010);
    check("out_res_low", mem_out_res, 1'b0);
    g = cyc;
    step();
    idle_inputs();
    wait_rsp(1'b1, g, lat, data);
    check("i_rd_latency", lat, L);
    check("i_rd_data", data, 32'hDEAD_BEEF);

    // Both ports reading every cycle: D first after reset, then alternate.
    step();
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 12'h010;
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 12'h011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_i_ready", bus.i_req_ready, k % 2 == 1);
      check("rr_d_ready", bus.d_req_ready, k % 2 == 0);
      check("rr_mem_addr", mem_rd_addr, (k % 2 == 1) ? 12'h010 : 12'h011);
      step();
    end
    idle_inputs();
    repeat (L + 2) step();

    // Partial write colliding with an instruction read of the same word.
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b1;
    bus.d_req_be    = 4'b0101;
    bus.d_req_addr  = 12'h020;
    bus.d_req_wdata = 32'h1122_3344;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 12'h020;
    @(negedge clk);
    check("hz_i_ready", bus.i_req_ready, 1'b0);
    check("hz_d_ready", bus.d_req_ready, 1'b1);
    check("hz_bwe", mem_byte_w_en, 4'b0101);
    step();
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    @(negedge clk);
    check("hz_retry_ready", bus.i_req_ready, 1'b1);
    g = cyc;
    step();
    idle_inputs();
    wait_rsp(1'b1, g, lat, data);
    check("hz_latency", lat, L);
    check("hz_data", data, 32'hFF22_FF44);

    // Write and instruction read to different words proceed together.
    step();
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b1;
    bus.d_req_be    = 4'hF;
    bus.d_req_addr  = 12'h030;
    bus.d_req_wdata = 32'hCAFE_F00D;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 12'h031;
    @(negedge clk);
    check("par_i_ready", bus.i_req_ready, 1'b1);
    check("par_d_ready", bus.d_req_ready, 1'b1);
    g = cyc;
    step();
    idle_inputs();
    wait_rsp(1'b1, g, lat, data);
    check("par_i_data", data, 32'hA500_0031);

    // Data read of the word just written.
    step();
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 12'h030;
    @(negedge clk);
    check("d_rd_ready", bus.d_req_ready, 1'b1);
    g = cyc;
    step();
    idle_inputs();
    wait_rsp(1'b0, g, lat, data);
    check("d_rd_latency", lat, L);
    check("d_rd_data", data, 32'hCAFE_F00D);

    // Reset pulse right after a grant drops the in-flight read.
    step();
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 12'h010;
    @(negedge clk);
    check("flush_grant", bus.i_req_ready, 1'b1);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_no_rsp", {bus.i_rsp_valid, bus.d_rsp_valid}, 2'b00);
    end

    repeat (3) step();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
